// File: rtl/compare_serial_ctrl.sv
// Serial MSB-first magnitude comparator controller.
// One bit stage per cycle, gated by a sticky equality chain.
module compare_serial_ctrl #(
    parameter int WIDTH      = 4,
    parameter int EARLY_EXIT = 1,
    parameter int SIGNED     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       busy,
    output logic                       done,
    output logic                       a_greater_b,
    output logic                       a_equal_b,
    output logic                       a_less_b,
    output logic [$clog2(WIDTH+1)-1:0] bits_used
);

    localparam int IW = $clog2(WIDTH);
    localparam int BW = $clog2(WIDTH+1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] a_r, b_r;
    logic [IW-1:0]    idx;
    logic             eq_chain;
    logic             dec_gt, dec_lt;
    logic             bit_a, bit_b;
    logic             swap;
    logic             gt_hit, lt_hit;
    logic             last;

    // Sign bit weighs negative, so its greater/less sense is flipped.
    always_comb begin
        bit_a  = a_r[idx];
        bit_b  = b_r[idx];
        swap   = (SIGNED != 0) && (idx == IW'(WIDTH-1));
        gt_hit = 1'b0;
        lt_hit = 1'b0;
        if (eq_chain) begin
            if (swap) begin
                gt_hit = ~bit_a & bit_b;
                lt_hit = bit_a & ~bit_b;
            end else begin
                gt_hit = bit_a & ~bit_b;
                lt_hit = ~bit_a & bit_b;
            end
        end
        last = (idx == '0) ||
               ((EARLY_EXIT != 0) && (gt_hit || lt_hit));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_n = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_n = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r         <= '0;
            b_r         <= '0;
            idx         <= '0;
            eq_chain    <= 1'b0;
            dec_gt      <= 1'b0;
            dec_lt      <= 1'b0;
            a_greater_b <= 1'b0;
            a_equal_b   <= 1'b0;
            a_less_b    <= 1'b0;
            bits_used   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_r         <= a;
                        b_r         <= b;
                        idx         <= IW'(WIDTH-1);
                        eq_chain    <= 1'b1;
                        dec_gt      <= 1'b0;
                        dec_lt      <= 1'b0;
                        a_greater_b <= 1'b0;
                        a_equal_b   <= 1'b0;
                        a_less_b    <= 1'b0;
                        bits_used   <= '0;
                    end
                end
                RUN: begin
                    bits_used <= bits_used + BW'(1);
                    if (!last) idx <= idx - IW'(1);
                    if (gt_hit || lt_hit) eq_chain <= 1'b0;
                    if (gt_hit) dec_gt <= 1'b1;
                    if (lt_hit) dec_lt <= 1'b1;
                    if (last) begin
                        a_greater_b <= dec_gt | gt_hit;
                        a_less_b    <= dec_lt | lt_hit;
                        a_equal_b   <= ~(dec_gt | gt_hit |
                                         dec_lt | lt_hit);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_compare_serial_ctrl.sv
// Scoreboard bench: four DUT variants (EARLY_EXIT x SIGNED)
// share stimulus; a timestamp model predicts every cycle.
module tb_compare_serial_ctrl;

    localparam int W = 4;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic [N-1:0] busy_v, done_v, gt_v, eq_v, lt_v;
    logic [2:0]   bu_v [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        compare_serial_ctrl #(
            .WIDTH(W),
            .EARLY_EXIT(g % 2),
            .SIGNED(g / 2)
        ) dut (
            .clk(clk),
            .rst(rst),
            .start(start),
            .a(a),
            .b(b),
            .busy(busy_v[g]),
            .done(done_v[g]),
            .a_greater_b(gt_v[g]),
            .a_equal_b(eq_v[g]),
            .a_less_b(lt_v[g]),
            .bits_used(bu_v[g])
        );
    end

    typedef struct {
        bit gt;
        bit eq;
        bit lt;
        int k;
        int d;
    } exp_t;

    exp_t exp_q [N][$];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    // per-variant model: accept edge, done cycle, result, prior result
    bit have [N];
    int acc  [N];
    int dcy  [N];
    exp_t cur  [N];
    exp_t prev [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%0d required=%0d",
                      nm, cyc, act, req);
    endtask

    function automatic exp_t ref_cmp(input logic [W-1:0] x,
                                     input logic [W-1:0] y,
                                     input bit sg, input bit ee);
        exp_t r;
        int vx, vy;
        bit found;
        vx = int'(x);
        vy = int'(y);
        if (sg && x[W-1]) vx -= (1 << W);
        if (sg && y[W-1]) vy -= (1 << W);
        r.gt = vx > vy;
        r.eq = vx == vy;
        r.lt = vx < vy;
        r.k = W;
        r.d = 0;
        found = 0;
        if (ee) begin
            for (int p = W - 1; p >= 0; p--) begin
                if (!found && x[p] != y[p]) begin
                    r.k = W - p;
                    found = 1;
                end
            end
        end
        return r;
    endfunction

    task automatic step(input bit r, input bit s,
                        input logic [W-1:0] av,
                        input logic [W-1:0] bv);
        @(negedge clk);
        rst = r;
        start = s;
        a = av;
        b = bv;
        for (int i = 0; i < N; i++) begin
            if (r) begin
                have[i] = 0;
                dcy[i] = -10;
                exp_q[i].delete();
            end else if (s && cyc >= dcy[i] + 1) begin
                prev[i] = have[i] ? cur[i] : '{0, 0, 0, 0, 0};
                cur[i] = ref_cmp(av, bv, i / 2, i % 2);
                acc[i] = cyc + 1;
                dcy[i] = acc[i] + cur[i].k;
                cur[i].d = dcy[i];
                have[i] = 1;
                exp_q[i].push_back(cur[i]);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, a, b);
    endtask

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
        step(0, 1, av, bv);
        step(0, 0, av, bv);
    endtask

    // monitor: per-cycle model check plus scoreboard pop on done
    initial begin
        exp_t e, p;
        int eb, ebusy, edone;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                e = '{0, 0, 0, 0, 0};
                eb = 0;
                ebusy = 0;
                edone = 0;
                if (have[i]) begin
                    if (cyc < acc[i]) begin
                        e = prev[i];
                        eb = prev[i].k;
                    end else if (cyc < dcy[i]) begin
                        eb = cyc - acc[i];
                        ebusy = 1;
                    end else begin
                        e = cur[i];
                        eb = cur[i].k;
                        ebusy = (cyc == dcy[i]);
                        edone = (cyc == dcy[i]);
                    end
                end
                chk($sformatf("busy[%0d]", i), int'(busy_v[i]), ebusy);
                chk($sformatf("done[%0d]", i), int'(done_v[i]), edone);
                chk($sformatf("gt[%0d]", i), int'(gt_v[i]), int'(e.gt));
                chk($sformatf("eq[%0d]", i), int'(eq_v[i]), int'(e.eq));
                chk($sformatf("lt[%0d]", i), int'(lt_v[i]), int'(e.lt));
                chk($sformatf("bits_used[%0d]", i), int'(bu_v[i]), eb);
                if (done_v[i] === 1'b1) begin
                    if (exp_q[i].size() == 0) begin
                        chk($sformatf("sb_empty[%0d]", i), 1, 0);
                    end else begin
                        p = exp_q[i].pop_front();
                        chk($sformatf("sb_cyc[%0d]", i), cyc, p.d);
                        chk($sformatf("sb_res[%0d]", i),
                            int'({gt_v[i], eq_v[i], lt_v[i]}),
                            int'({p.gt, p.eq, p.lt}));
                        chk($sformatf("sb_bits[%0d]", i),
                            int'(bu_v[i]), p.k);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            have[i] = 0;
            acc[i] = 0;
            dcy[i] = -10;
        end
        step(1, 0, '0, '0);
        step(1, 0, '0, '0);
        idle(3);
        issue(4'b1010, 4'b0111);
        idle(6);
        issue(4'b0110, 4'b0110);
        idle(6);
        issue(4'b0110, 4'b0111);
        idle(6);
        issue(4'b1111, 4'b0001);
        idle(6);
        // start pulses while busy must be dropped
        step(0, 1, 4'b0101, 4'b0101);
        step(0, 1, 4'b1110, 4'b0001);
        step(0, 1, 4'b0001, 4'b1110);
        step(0, 0, 4'b0011, 4'b1100);
        idle(6);
        // abort after two RUN edges, then a clean run
        issue(4'b0110, 4'b0110);
        step(0, 0, a, b);
        step(1, 1, 4'b1000, 4'b0001);
        step(0, 0, a, b);
        issue(4'b1000, 4'b0001);
        idle(6);
        for (int t = 0; t < 800; t++) begin
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 2) == 0,
                 W'($urandom), W'($urandom));
        end
        idle(10);
        for (int i = 0; i < N; i++)
            chk($sformatf("sb_left[%0d]", i), exp_q[i].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
